// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM pipeline stage and the data memory.
interface mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/BUSY/DONE data-memory access FSM that stalls the front of the pipe.
// Optional macro MEM_TIMEOUT_EN adds a BUSY watchdog that aborts the access and pulses MemError.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   input  logic [4:0]  RegWriteAdd,
   mem_stage_if.master mem,
   output logic [31:0] MemoryData_Out,
   output logic [31:0] ALUResult_Out,
   output logic        RegWrite_Out,
   output logic        MemtoReg_Out,
   output logic [4:0]  RegWriteAdd_Out,
   output logic        Stall,
   output logic        MemError
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_data;
   logic        r_we;
   logic        r_req;
   logic        w_access;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_stage: TIMEOUT_CYCLES must lie in 2..255");
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_cnt;
   logic       r_err;
`endif

   assign w_access = MemRead | MemWrite;

   // Access sequencer: latches the request, waits for ack (or watchdog), then holds result for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_data  <= 32'd0;
         r_we    <= 1'b0;
         r_req   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_cnt   <= 8'd0;
         r_err   <= 1'b0;
`endif
      end else begin
`ifdef MEM_TIMEOUT_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  r_state <= BUSY;
                  r_req   <= 1'b1;
                  r_addr  <= ALUResult;
                  r_wdata <= WriteData;
                  // MemWrite wins when both strobes are set, so a read+write acts as a store.
                  r_we    <= MemWrite;
`ifdef MEM_TIMEOUT_EN
                  r_cnt   <= 8'd0;
`endif
               end else begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               if (mem.mem_ack) begin
                  r_state <= DONE;
                  r_req   <= 1'b0;
                  r_data  <= r_we ? 32'd0 : mem.mem_rdata;
               end
`ifdef MEM_TIMEOUT_EN
               else if (r_cnt == CNT_LAST) begin
                  r_state <= DONE;
                  r_req   <= 1'b0;
                  r_data  <= 32'd0;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + 8'd1;
               end
`else
               else begin
                  r_state <= BUSY;
               end
`endif
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   assign MemError = r_err;
`else
   assign MemError = 1'b0;
`endif

   assign mem.mem_req   = r_req;
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

   assign Stall           = ((r_state == IDLE) && w_access) || (r_state == BUSY);
   assign MemoryData_Out  = (r_state == DONE) ? r_data : 32'd0;
   assign ALUResult_Out   = ALUResult;
   assign MemtoReg_Out    = MemtoReg;
   assign RegWriteAdd_Out = RegWriteAdd;
   // A stalled instruction must not write back; it enters MEM/WB as a bubble.
   assign RegWrite_Out    = RegWrite & ~Stall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: random accesses scored against a cycle-count/value model.
module tb_mem_stage;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
   logic [31:0] ALUResult = 32'd0, WriteData = 32'd0;
   logic [4:0]  RegWriteAdd = 5'd0;
   logic [31:0] MemoryData_Out, ALUResult_Out;
   logic        RegWrite_Out, MemtoReg_Out, Stall, MemError;
   logic [4:0]  RegWriteAdd_Out;

   mem_stage_if mif ();

   mem_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .ALUResult(ALUResult), .WriteData(WriteData), .RegWriteAdd(RegWriteAdd),
      .mem(mif),
      .MemoryData_Out(MemoryData_Out), .ALUResult_Out(ALUResult_Out),
      .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
      .RegWriteAdd_Out(RegWriteAdd_Out), .Stall(Stall), .MemError(MemError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        rw;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   logic prev_stall = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
   endtask

   // Number of BUSY cycles an access lasts, given the BUSY cycle (1-based) in which ack arrives.
   function automatic int exp_busy(input int ack_at);
`ifdef MEM_TIMEOUT_EN
      if (ack_at == 0 || ack_at > T) return T;
`endif
      return ack_at;
   endfunction

   // Monitor: a falling Stall marks the DONE cycle; score it against the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && !Stall) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               check("done_data", MemoryData_Out, sb[0].data);
               check("done_regwrite", {31'd0, RegWrite_Out}, {31'd0, sb[0].rw});
               check("done_memerror", {31'd0, MemError}, {31'd0, sb[0].err});
               check("done_req", {31'd0, mif.mem_req}, 32'd0);
               void'(sb.pop_front());
            end
         end
         prev_stall <= Stall;
      end
   end

   task automatic nop();
      MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
      ALUResult = 32'd0; WriteData = 32'd0; RegWriteAdd = 5'd0;
      mif.mem_ack = 1'b0;
   endtask

   task automatic do_mem(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic rw, input logic m2r, input logic [4:0] rwa,
                         input int ack_at);
      int   busy_n;
      int   stall_cnt;
      int   cyc;
      logic tout;
      exp_t e;
      busy_n = exp_busy(ack_at);
      tout   = (busy_n != ack_at);
      e.data = (tout || wr) ? 32'd0 : rdata;
      e.rw   = rw;
      e.err  = tout;
      sb.push_back(e);
      MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wdata;
      RegWrite = rw; MemtoReg = m2r; RegWriteAdd = rwa;
      mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
      stall_cnt = 0;
      cyc = 0;
      while (cyc < 60) begin
         @(negedge clk);
         if (!Stall) break;
         stall_cnt++;
         check("bubble_regwrite", {31'd0, RegWrite_Out}, 32'd0);
         check("stalled_data_out", MemoryData_Out, 32'd0);
         check("stalled_memerror", {31'd0, MemError}, 32'd0);
         check("req_level", {31'd0, mif.mem_req}, (cyc >= 1) ? 32'd1 : 32'd0);
         if (cyc >= 1) begin
            check("busy_addr", mif.mem_addr, addr);
            check("busy_wdata", mif.mem_wdata, wdata);
            check("busy_we", {31'd0, mif.mem_we}, {31'd0, wr});
         end
         @(posedge clk); #1;
         cyc++;
         mif.mem_ack   = (cyc == ack_at);
         mif.mem_rdata = (cyc == ack_at) ? rdata : $urandom;
      end
      check("stall_cycles", stall_cnt, busy_n + 1);
      check("done_alu_pass", ALUResult_Out, addr);
      check("done_rwa_pass", {27'd0, RegWriteAdd_Out}, {27'd0, rwa});
      @(posedge clk); #1;
      nop();
   endtask

   task automatic do_alu(input logic [31:0] res, input logic rw, input logic m2r,
                         input logic [4:0] rwa, input logic spurious);
      MemRead = 1'b0; MemWrite = 1'b0; ALUResult = res; WriteData = $urandom;
      RegWrite = rw; MemtoReg = m2r; RegWriteAdd = rwa;
      mif.mem_ack = spurious; mif.mem_rdata = $urandom;
      #1;
      check("alu_stall", {31'd0, Stall}, 32'd0);
      check("alu_result", ALUResult_Out, res);
      check("alu_regwrite", {31'd0, RegWrite_Out}, {31'd0, rw});
      check("alu_memtoreg", {31'd0, MemtoReg_Out}, {31'd0, m2r});
      check("alu_rwa", {27'd0, RegWriteAdd_Out}, {27'd0, rwa});
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      check("alu_idle_req", {31'd0, mif.mem_req}, 32'd0);
      check("alu_idle_stall", {31'd0, Stall}, 32'd0);
      check("alu_idle_data", MemoryData_Out, 32'd0);
      nop();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, {31'd0, mif.mem_req}, 32'd0);
      check({tag, "_addr"}, mif.mem_addr, 32'd0);
      check({tag, "_wdata"}, mif.mem_wdata, 32'd0);
      check({tag, "_we"}, {31'd0, mif.mem_we}, 32'd0);
      check({tag, "_data"}, MemoryData_Out, 32'd0);
      check({tag, "_err"}, {31'd0, MemError}, 32'd0);
      check({tag, "_stall"}, {31'd0, Stall}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mif.mem_ack = 1'b0;
      mif.mem_rdata = 32'd0;
      #12;
      check_reset_values("reset");
      @(negedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;

      do_mem(1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'h1234_5678, 1'b1, 1'b1, 5'd3, 1);
      do_mem(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 32'h5555_AAAA, 1'b0, 1'b0, 5'd0, 4);
      do_alu(32'h0000_0007, 1'b1, 1'b0, 5'd9, 1'b1);
      do_mem(1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd7, 2);
      do_mem(1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'hA5A5_5A5A, 1'b1, 1'b1, 5'd1, T);
      // No ack for 40 BUSY cycles: aborts at T with the watchdog, else the stall simply persists.
      do_mem(1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'h0F0F_0F0F, 1'b1, 1'b1, 5'd2, 40);

      // Reset mid-BUSY must drop mem_req at once; a late ack must be ignored.
      MemRead = 1'b1; ALUResult = 32'h0000_0400; RegWrite = 1'b1;
      @(posedge clk);
      @(posedge clk); #3;
      check("pre_rst_req", {31'd0, mif.mem_req}, 32'd1);
      rst = 1'b0; MemRead = 1'b0; RegWrite = 1'b0;
      #1;
      check_reset_values("midbusy_rst");
      check("midbusy_rst_regwrite", {31'd0, RegWrite_Out}, 32'd0);
      @(negedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      check("late_ack_req", {31'd0, mif.mem_req}, 32'd0);
      check("late_ack_stall", {31'd0, Stall}, 32'd0);
      check("late_ack_data", MemoryData_Out, 32'd0);
      do_mem(1'b1, 1'b0, 32'h0000_0044, 32'd0, 32'h0102_0304, 1'b1, 1'b1, 5'd4, 1);

      for (int i = 0; i < 24; i++) begin
         int kind;
         kind = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0)
            do_alu($urandom, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
         do_mem(kind != 1, kind != 0, $urandom, $urandom, $urandom,
                1'($urandom), 1'($urandom), 5'($urandom), $urandom_range(1, 6));
      end

      @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, number of BUSY cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN; legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 MemRead, MemWrite  input  1 each  access request from the EX/MEM register.
REQ-005 RegWrite, MemtoReg  input  1 each  writeback controls from the EX/MEM register.
REQ-006 ALUResult  input  32  memory address / ALU result; WriteData  input  32  store data.
REQ-007 RegWriteAdd  input  5  destination register number.
REQ-008 mem_req, mem_we  output  1 each  data-memory request and write strobe.
REQ-009 mem_addr, mem_wdata  output  32 each  latched address and store data.
REQ-010 mem_rdata  input  32  load data; mem_ack  input  1  one-cycle completion strobe.
REQ-011 MemoryData_Out, ALUResult_Out  output  32 each  values feeding the MEM/WB register.
REQ-012 RegWrite_Out, MemtoReg_Out  output  1 each; RegWriteAdd_Out  output  5.
REQ-013 Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-014 MemError  output  1  one-cycle abort indication (MEM_TIMEOUT_EN only).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 IDLE: if MemRead or MemWrite is high, next state BUSY, latching ALUResult->mem_addr, WriteData->mem_wdata and MemWrite->mem_we; otherwise stay IDLE.
REQ-017 BUSY: mem_req SHALL be 1; on mem_ack=1 capture mem_rdata (load) or 0 (store) into the data register and go to DONE.
REQ-018 DONE: unconditionally return to IDLE after one cycle; mem_req SHALL be 0.
REQ-019 mem_req SHALL be 0 in IDLE and DONE; mem_addr, mem_wdata and mem_we SHALL hold stable throughout BUSY.
REQ-020 Stall SHALL be combinational: 1 when (IDLE and (MemRead or MemWrite)) or BUSY; otherwise 0.
REQ-021 An access takes at least 3 cycles (IDLE->BUSY->DONE); with ack in the first BUSY cycle, Stall is high exactly 2 cycles.
REQ-022 MemoryData_Out SHALL equal the data register in DONE and 0 in all other states.
REQ-023 ALUResult_Out, MemtoReg_Out and RegWriteAdd_Out SHALL pass ALUResult, MemtoReg and RegWriteAdd combinationally.
REQ-024 RegWrite_Out SHALL equal RegWrite and not Stall, so a stalled instruction enters MEM/WB as a bubble.
REQ-025 MemRead and MemWrite both high SHALL be treated as a store; the data register is loaded with 0.
REQ-026 mem_ack outside BUSY SHALL be ignored and change no state.
REQ-027 A non-memory instruction (MemRead=MemWrite=0) SHALL pass with zero added latency and Stall=0.

Reset
REQ-028 While rst=0, the block SHALL immediately force state=IDLE, data register=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_req=0, MemError=0 and the timeout counter to 0.
REQ-029 Reset asserted in BUSY SHALL drop mem_req asynchronously; an ack arriving after reset release SHALL be ignored per REQ-026.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when it reaches TIMEOUT_CYCLES-1 with no ack, the FSM SHALL go to DONE with data register=0 and MemError=1 for that DONE cycle only.
REQ-031 Macro MEM_TIMEOUT_EN undefined: BUSY SHALL wait for mem_ack indefinitely, no counter SHALL be built and MemError SHALL be constant 0.

Verification
REQ-032 Load, addr 0x00000040, ack on 1st BUSY cycle with rdata 0x12345678 -> Stall high 2 cycles; DONE: MemoryData_Out=0x12345678, RegWrite_Out=1.
REQ-033 Store, addr 0x80, WriteData 0xCAFEF00D, ack after 4 BUSY cycles -> mem_we=1, mem_addr/mem_wdata stable for all 4 cycles; Stall high 5 cycles; MemoryData_Out=0.
REQ-034 ALU op (MemRead=MemWrite=0, ALUResult 0x7) -> Stall=0, ALUResult_Out=0x7 same cycle; spurious mem_ack -> state remains IDLE.
REQ-035 rst=0 driven mid-BUSY -> mem_req=0 before the next clk edge, state IDLE, all outputs at reset values; late ack ignored.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 BUSY cycles: DONE, MemError=1 for 1 cycle, MemoryData_Out=0; without the macro the same stimulus -> Stall held high indefinitely.
